// File: rtl/product_bcd_converter.sv
// Serial binary-to-BCD converter (shift-add-3, one bit per clock) for the multiplier product.
// Define PRODUCT_BCD_SEG7_EN to add an active-low 7-segment decode output `seg`.
module product_bcd_converter #(
  parameter int unsigned IN_W   = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
`ifdef PRODUCT_BCD_SEG7_EN
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
`else
  output logic [4*DIGITS-1:0]   bcd
`endif
);

  localparam int unsigned CW = $clog2(IN_W + 1);
  localparam logic [CW-1:0] LastCount = CW'(IN_W - 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // The largest binary input must fit in the requested number of decimal digits.
  if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_digits_check
    $error("product_bcd_converter: DIGITS too small for IN_W");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [IN_W-1:0]       shift_q, shift_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         count_q, count_d;
  logic [4*DIGITS-1:0]   adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      count_q   <= count_d;
    end
  end

  // Add-3 correction of every digit >= 5 before each shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          count_d   = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        count_d = count_q + 1'b1;
        if (count_q == LastCount) begin
          bcd_d   = scratch_d;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign bcd  = bcd_q;

`ifdef PRODUCT_BCD_SEG7_EN
  // Segment order {g,f,e,d,c,b,a}, active low.
  always_comb begin
    seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      case (bcd_q[4*i +: 4])
        4'd0:    seg[7*i +: 7] = 7'b1000000;
        4'd1:    seg[7*i +: 7] = 7'b1111001;
        4'd2:    seg[7*i +: 7] = 7'b0100100;
        4'd3:    seg[7*i +: 7] = 7'b0110000;
        4'd4:    seg[7*i +: 7] = 7'b0011001;
        4'd5:    seg[7*i +: 7] = 7'b0010010;
        4'd6:    seg[7*i +: 7] = 7'b0000010;
        4'd7:    seg[7*i +: 7] = 7'b1111000;
        4'd8:    seg[7*i +: 7] = 7'b0000000;
        4'd9:    seg[7*i +: 7] = 7'b0010000;
        default: seg[7*i +: 7] = 7'b1111111;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed self-checking bench for product_bcd_converter (IN_W=6, DIGITS=2).
module tb_product_bcd_converter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] bin = '0;
  logic       busy;
  logic       done;
  logic [7:0] bcd;
`ifdef PRODUCT_BCD_SEG7_EN
  logic [13:0] seg;
`endif

  int checks = 0;
  int errors = 0;

  product_bcd_converter #(
    .IN_W   (6),
    .DIGITS (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef PRODUCT_BCD_SEG7_EN
    .bcd   (bcd),
    .seg   (seg)
`else
    .bcd   (bcd)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef PRODUCT_BCD_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
`endif

  // Waits (bounded) for done; returns the number of edges after the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic convert(input string tag, input logic [5:0] v, input logic [7:0] exp);
    int n;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1'b1);
    wait_done(n);
    check({tag, " latency"}, n, 6);
    check({tag, " bcd"}, bcd, exp);
    check({tag, " busy_in_done"}, busy, 1'b1);
`ifdef PRODUCT_BCD_SEG7_EN
    check({tag, " seg"}, seg, {seg7(exp[7:4]), seg7(exp[3:0])});
`endif
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " idle_after"}, busy, 1'b0);
    check({tag, " bcd_hold"}, bcd, exp);
  endtask

  initial begin
    int n;
    int seen_done;
    logic [7:0] e;

    // Reset state while rst is held
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst bcd", bcd, 8'h00);
`ifdef PRODUCT_BCD_SEG7_EN
    check("rst seg", seg, 14'b1000000_1000000);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle with start low: nothing happens
    repeat (3) @(posedge clk);
    #1;
    check("idle busy", busy, 1'b0);

    convert("zero", 6'd0, 8'h00);
    convert("49", 6'd49, 8'h49);
    convert("63", 6'd63, 8'h63);
    convert("10", 6'd10, 8'h10);

    // start held high and bin changed while busy
    @(negedge clk);
    bin   = 6'd25;
    start = 1'b1;
    @(posedge clk);
    #1;
    bin = 6'd12;
    wait_done(n);
    check("hold latency", n, 6);
    check("hold bcd25", bcd, 8'h25);
    @(posedge clk);
    #1;
    check("hold done_low", done, 1'b0);
    check("hold idle", busy, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hold restart busy", busy, 1'b1);
    wait_done(n);
    check("hold latency2", n, 6);
    check("hold bcd12", bcd, 8'h12);
    @(posedge clk);
    #1;

    // Abort by reset mid-conversion
    @(negedge clk);
    bin   = 6'd36;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy_async", busy, 1'b0);
    check("abort bcd_async", bcd, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    check("abort no_done", seen_done, 0);
    check("abort busy", busy, 1'b0);
    check("abort bcd", bcd, 8'h00);
    convert("36", 6'd36, 8'h36);

    // All multiplier products
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        e = 8'(((x * y) / 10) * 16 + ((x * y) % 10));
        convert($sformatf("prod %0d*%0d", x, y), 6'(x * y), e);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Sequential binary-to-BCD converter placed directly downstream of the 3-bit combinational multiplier.
- Takes the 6-bit product (0..49 in practice, 0..63 legal) and converts it to packed BCD digits using shift-add-3 (double dabble), one bit per clock.
- Its output feeds the board display path; an optional on-block 7-segment decode can be compiled in.

Parameters:
- IN_W, 6, width of binary input (multiplier product width).
- DIGITS, 2, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_W - 1 (elaboration-time check, $error on violation).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to convert bin; sampled only in IDLE.
- bin  input  IN_W  binary value (multiplier p output).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse: bcd holds a new result.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0], digit i in bits [4i+3:4i].

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, bcd=0, internal shift/count registers=0; takes effect immediately regardless of clk.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1 at edge k, capture bin into shift register, clear scratch BCD register, count=0, go to SHIFT. If start=0, stay in IDLE; outputs hold.
- SHIFT: each edge, every scratch BCD digit >= 5 gets +3 (4-bit add, no carry out), then {scratch, shift} shifts left 1; count++. After IN_W shifts (edges k+1..k+IN_W), at edge k+IN_W load bcd from the final scratch value and go to DONE.
- DONE: done=1 for exactly this cycle; at the next edge (k+IN_W+1) go to IDLE, done=0.
- Latency: start at edge k -> done high in the cycle following edge k+IN_W (7 cycles for IN_W=6); a new start is accepted at edge k+IN_W+2 at the earliest.
- start while busy (SHIFT or DONE) is ignored, with no queueing; bin is only sampled at the accepting edge.
- bcd changes only at the DONE-entry edge or on reset; it holds the last result indefinitely.
- Count register width: $clog2(IN_W+1).
- rst asserted mid-conversion: abort, all outputs to reset values, and no done pulse.
- bin=0 -> bcd=0. bin = 2^IN_W-1 must convert correctly.

Optional Feature:
- Macro PRODUCT_BCD_SEG7_EN.
- Defined: adds output seg [7*DIGITS-1:0], active-low segments ordered {g,f,e,d,c,b,a} per digit, with digit i in bits [7i+6:7i].
  - Combinational decode of the registered bcd, so it tracks bcd and equals 7'b1000000 per digit after reset.
  - Codes: 0=1000000, 4=0011001, 9=0010000; standard patterns for the other digits; codes 10-15 never occur (decode to 1111111).
- Undefined: seg port and decode logic are absent; all other behaviour is identical.

Test Plan:
- Reset then bin=6'd0, start pulse -> done high in cycle after edge k+6, bcd=8'h00, busy high for 7 cycles.
- bin=6'd49 (7*7 from multiplier), start -> bcd=8'h49, exactly one done pulse; with PRODUCT_BCD_SEG7_EN, seg={0011001,0010000}.
- bin=6'd63 -> bcd=8'h63; bin=6'd10 -> bcd=8'h10 (digit carry boundary).
- Convert 6'd25; hold start=1 and change bin to 6'd12 during SHIFT/DONE -> result 8'h25 only, no second done until start is re-sampled in IDLE; the next conversion then yields 8'h12.
- Start 6'd36, assert rst at edge k+3 for 1 cycle -> busy=0, done never pulses, bcd=8'h00; a subsequent start with 6'd36 -> bcd=8'h36.
- Sweep all products x*y for x,y in 0..7 through the multiplier into this block -> bcd matches decimal of x*y every time.
